// File: rtl/zone_event_pkg.sv
// Shared types and constants for the zone event logger.
// Zone codes match the price threshold detector output.
package zone_event_pkg;

    typedef enum logic [1:0] {
        ZONE_IDLE = 2'b00,
        ZONE_BAND = 2'b01,
        ZONE_LOW  = 2'b10,
        ZONE_HIGH = 2'b11
    } zone_t;

    localparam int TS_MAX_WIDTH = 32;

    // Widest record; the logger packs only TS_WIDTH bits of stamp.
    typedef struct packed {
        zone_t                   from;
        zone_t                   to;
        logic [TS_MAX_WIDTH-1:0] stamp;
    } zone_event_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous show-ahead FIFO.
// dout holds the last popped entry while empty.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/zone_event_logger.sv
// Timestamps zone changes and queues them for a host reader.
// Define ZONE_EVENT_DROP_CNT_EN to build the dropped-event counter.
module zone_event_logger
    import zone_event_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          zone,
    input  logic                ev_ready,
    input  logic                clr_ovf,
    output logic                ev_valid,
    output logic [1:0]          ev_from,
    output logic [1:0]          ev_to,
    output logic [TS_WIDTH-1:0] ev_time,
    output logic [CW-1:0]       ev_count,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);

    localparam int W = 4 + TS_WIDTH;

    logic [1:0]          prev_zone;
    logic [TS_WIDTH-1:0] ts;
    logic                change;
    logic                full;
    logic                empty;
    logic                pop;
    logic                drop;
    logic [W-1:0]        din;
    logic [W-1:0]        dout;

    assign change = (zone != prev_zone);
    assign pop    = ev_ready && !empty;
    assign drop   = change && full && !pop;
    assign din    = {prev_zone, zone, ts};

    assign ev_valid = !empty;
    assign ev_from  = dout[W-1 -: 2];
    assign ev_to    = dout[W-3 -: 2];
    assign ev_time  = dout[TS_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_zone <= ZONE_IDLE;
            ts        <= '0;
        end else begin
            prev_zone <= zone;
            ts        <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

`ifdef ZONE_EVENT_DROP_CNT_EN
    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= 8'd0;
        else if (drop && clr_ovf)
            drop_cnt <= 8'd1;
        else if (drop && drop_cnt != DROP_CNT_MAX)
            drop_cnt <= drop_cnt + 8'd1;
        else if (!drop && clr_ovf)
            drop_cnt <= 8'd0;
    end
`else
    assign drop_cnt = 8'd0;
`endif

    event_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (change),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (ev_count)
    );

endmodule

// File: tb/tb_zone_event_logger.sv
// Randomized bench for zone_event_logger against a queue-based model.
// Directed scenarios first, then a random soak with occasional resets.
module tb_zone_event_logger;

    localparam int DEPTH = 4;
    localparam int TSW   = 8;

    logic           clk;
    logic           reset;
    logic [1:0]     zone;
    logic           ev_ready;
    logic           clr_ovf;
    logic           ev_valid;
    logic [1:0]     ev_from;
    logic [1:0]     ev_to;
    logic [TSW-1:0] ev_time;
    logic [2:0]     ev_count;
    logic           overflow;
    logic [7:0]     drop_cnt;

    zone_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk      (clk),
        .reset    (reset),
        .zone     (zone),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_from  (ev_from),
        .ev_to    (ev_to),
        .ev_time  (ev_time),
        .ev_count (ev_count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int from;
        int to;
        int stamp;
    } rec_t;

    rec_t q[$];
    rec_t mlast;
    int   mts;
    int   mprev;
    bit   movf;
    int   mdrop;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mlast = '{0, 0, 0};
        mts   = 0;
        mprev = 0;
        movf  = 0;
        mdrop = 0;
    endtask

    task automatic model_edge(input int z, input bit r, input bit c);
        bit drop;
        drop = 0;
        if (r && q.size() > 0)
            mlast = q.pop_front();
        if (z != mprev) begin
            if (q.size() < DEPTH)
                q.push_back('{mprev, z, mts});
            else
                drop = 1;
        end
        if (drop) begin
            movf  = 1;
            mdrop = c ? 1 : (mdrop < 255 ? mdrop + 1 : 255);
        end else if (c) begin
            movf  = 0;
            mdrop = 0;
        end
        mprev = z;
        mts   = (mts + 1) % 256;
    endtask

    task automatic compare_all();
        rec_t h;
        int   dexp;
        h = (q.size() > 0) ? q[0] : mlast;
`ifdef ZONE_EVENT_DROP_CNT_EN
        dexp = mdrop;
`else
        dexp = 0;
`endif
        check("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
        check("ev_count", 32'(ev_count), 32'(q.size()));
        check("ev_from", 32'(ev_from), 32'(h.from));
        check("ev_to", 32'(ev_to), 32'(h.to));
        check("ev_time", 32'(ev_time), 32'(h.stamp));
        check("overflow", 32'(overflow), 32'(movf));
        check("drop_cnt", 32'(drop_cnt), 32'(dexp));
    endtask

    task automatic cyc(input logic [1:0] z, input logic r, input logic c);
        zone     = z;
        ev_ready = r;
        clr_ovf  = c;
        @(posedge clk);
        model_edge(int'(z), r, c);
        @(negedge clk);
        compare_all();
    endtask

    // Reset pulse between edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_count", 32'(ev_count), 0);
        check("rst_head", {ev_from, ev_to, ev_time}, 0);
        check("rst_ovf", {overflow, drop_cnt}, 0);
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        model_edge(int'(zone), ev_ready, clr_ovf);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [1:0] z;
        reset    = 1'b1;
        zone     = 2'b00;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Single change after five idle cycles
        repeat (5) cyc(2'b00, 0, 0);
        cyc(2'b01, 0, 0);
        check("first_time", 32'(ev_time), 5);
        check("first_to", 32'(ev_to), 1);

        // Back-to-back changes
        cyc(2'b11, 0, 0);
        cyc(2'b10, 0, 0);
        cyc(2'b01, 0, 0);
        check("b2b_count", 32'(ev_count), 4);

        // Overflow: drain, then six changes with no reader
        repeat (5) cyc(2'b01, 1, 0);
        z = 2'b01;
        for (int i = 0; i < 6; i++) begin
            z = z + 2'b01;
            cyc(z, 0, 0);
        end
        check("ovf_flag", 32'(overflow), 1);
        repeat (5) cyc(z, 1, 0);
        cyc(z, 0, 1);
        check("ovf_clr", 32'(overflow), 0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) begin
            z = z + 2'b01;
            cyc(z, 0, 0);
        end
        z = z + 2'b01;
        cyc(z, 1, 0);
        check("full_pp_ovf", 32'(overflow), 0);
        check("full_pp_cnt", 32'(ev_count), 4);

        // Timestamp wrap
        repeat (6) cyc(z, 1, 0);
        while (mts != 255) cyc(z, 1, 0);
        cyc(z + 2'b01, 0, 0);
        z = z + 2'b01;
        cyc(z, 0, 0);
        cyc(z + 2'b10, 0, 0);
        check("wrap_head", 32'(ev_time), 255);
        cyc(z + 2'b10, 1, 0);
        check("wrap_next", 32'(ev_time), 1);

        // Async reset with three events queued, zone held at 01
        repeat (4) cyc(2'b00, 1, 0);
        cyc(2'b01, 0, 0);
        cyc(2'b10, 0, 0);
        cyc(2'b01, 0, 0);
        mid_reset();
        check("post_rst_cnt", 32'(ev_count), 1);
        check("post_rst_to", 32'(ev_to), 1);

        // Random soak
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                z = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : zone;
                cyc(z, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zone_event_logger.md
# zone_event_logger

Downstream consumer of the price threshold detector's 2-bit zone code (IDLE/BAND/LOW/HIGH). It samples the zone every cycle, detects zone changes, and timestamps each change with a free-running cycle counter. Each change is queued as an event record in a show-ahead FIFO, which a host-side reader drains through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- TS_WIDTH, 16, timestamp counter width; 8..32.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- zone  input  2  detector output code, sampled every cycle.
- ev_ready  input  1  consumer accepts head event this cycle.
- clr_ovf  input  1  synchronous clear of `overflow` and `drop_cnt`.
- ev_valid  output  1  head event present.
- ev_from  output  2  zone before the change.
- ev_to  output  2  zone after the change.
- ev_time  output  TS_WIDTH  timestamp of the change.
- ev_count  output  $clog2(DEPTH+1)  occupied entries.
- overflow  output  1  sticky; an event was dropped.
- drop_cnt  output  8  dropped-event count, saturating.

## Operation
- `prev_zone` register:
  - Reset value 2'b00.
  - Loads `zone` every cycle.
- Event condition: `zone != prev_zone` at a rising edge. This includes the first exit from IDLE after reset.
- Record contents: {from=prev_zone, to=zone, time=ts}.
  - `ts` is the counter value before that edge's increment.
- `ts`:
  - Reset value 0.
  - Increments every cycle.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- FIFO behaviour:
  - Show-ahead: ev_from/ev_to/ev_time always reflect the head entry.
  - When empty, these outputs hold their last values; all zero after reset.
  - Pop occurs when ev_valid && ev_ready.
- Push/pop rules:
  - Empty, push: entry written; ev_valid rises next cycle.
  - Empty, ev_ready high: no effect.
  - Full, push without pop: event dropped, `overflow` set, drop_cnt+1 (saturates at 255); FIFO unchanged.
  - Full, push with simultaneous pop: push accepted; count stays DEPTH.
  - Push and pop simultaneously at any other occupancy: count unchanged.
- clr_ovf:
  - Clears `overflow` and `drop_cnt` next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Reset mid-operation: FIFO emptied, ts=0, prev_zone=00, and all outputs return to 0 asynchronously. In-flight events are lost.

## Timing
- Latency from zone change to ev_valid: 1 cycle when the FIFO is empty. The zone changes before edge N; ev_valid is high after edge N.
- ev_count updates on the same edge as the push or pop.
- The reader may hold ev_ready high continuously, giving one pop per cycle at full throughput.
- No combinational path from `zone` to any output; every output is registered or driven from FIFO storage.
- Reset values of all outputs are 0.

## Configuration
- Macro `ZONE_EVENT_DROP_CNT_EN`:
  - Defined: drop_cnt operates as above.
  - Undefined: drop_cnt is tied to 8'd0 and the counter logic is removed. `overflow` is still implemented.

## Structure
- Package `zone_event_pkg` contents:
  - enum `zone_t`: ZONE_IDLE=2'b00, ZONE_BAND=2'b01, ZONE_LOW=2'b10, ZONE_HIGH=2'b11.
  - Parameterized struct/typedef `zone_event_t` {from, to, time}.
  - Constant DROP_CNT_MAX=255.
- Sub-module `event_fifo`:
  - Generic synchronous show-ahead FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Asynchronous active-high reset.
- Top level: change detect, timestamp counter, drop/overflow logic.

## Test plan
(DEPTH=4, TS_WIDTH=8 unless noted.)
- **Reset then single change:** after reset, hold zone=00 for 5 cycles, then zone=01 at ts=5 → ev_valid=1 next cycle with from=00, to=01, time=5; ev_count=1.
- **Back-to-back changes:** zone 01→11→10→01 on consecutive cycles, ev_ready=0 → 3 entries in order with times t, t+1, t+2; ev_count=3.
- **Overflow:** 6 changes with ev_ready=0 → ev_count=4, overflow=1, drop_cnt=2.
  - Drain with ev_ready=1 → exactly the first 4 events, in order.
  - clr_ovf → overflow=0, drop_cnt=0.
- **Full with simultaneous push/pop:** FIFO full, ev_ready=1, and a change in the same cycle → new event accepted, ev_count=4, overflow remains 0.
- **Timestamp wrap:** change at ts=255 and another at ts=1 → ev_time 255, then 1.
- **Async reset mid-stream:** 3 events queued, assert reset between edges → ev_valid, ev_count, and ev_* are 0 immediately.
  - After release, zone=01 held (unchanged) → one event from=00, to=01 is logged.
